slow_tick_gen: RTL and testbench
================================

SLOW_TICK_GEN -- requirements
Module: slow_tick_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 8, the divisor width in bits.
REQ-002 SHALL have parameter DIV_RST, default 7, the divisor value loaded at reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin tick generation.
REQ-006 SHALL have port stop, input, 1 bit: request to halt tick generation.
REQ-007 SHALL have port div_load, input, 1 bit: divisor load strobe.
REQ-008 SHALL have port div_val, input, DIV_W bits: the divisor value offered with div_load.
REQ-009 SHALL have port div_ready, output, 1 bit: high when a divisor load will be accepted.
REQ-010 SHALL have port slow, output, 1 bit: the slow enable driven to the downstream slow counter.
REQ-011 SHALL have port running, output, 1 bit: high while the state is RUN.
REQ-012 SHALL have port tick_cnt, output, 4 bits: the number of ticks generated, modulo 16.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and RUN; running SHALL equal (state==RUN).
REQ-014 In IDLE, start=1 and stop=0 SHALL move the FSM to RUN and load the prescaler with div_reg.
REQ-015 In IDLE, start=1 together with stop=1 SHALL leave the FSM in IDLE.
REQ-016 In RUN, start SHALL be ignored.
REQ-017 In RUN, stop=1 SHALL move the FSM to IDLE and clear the prescaler; no tick SHALL be generated that cycle, even at terminal count.
REQ-018 In RUN, the prescaler SHALL decrement each cycle; at 0 it SHALL emit one tick and reload.
REQ-019 The period SHALL be div_reg+1 clocks; div_reg=0 SHALL give a tick every cycle.
REQ-020 The first tick SHALL occur div_reg+1 cycles after the cycle in which start is accepted.
REQ-021 The divisor handshake SHALL accept a load when div_load=1 and div_ready=1; div_load SHALL be ignored while div_ready=0.
REQ-022 In IDLE, div_ready SHALL be 1, and an accepted value SHALL be written to div_reg on the next edge.
REQ-023 In RUN, an accepted value SHALL be held as pending, and div_ready SHALL be 0 until the pending value is applied.
REQ-024 A pending value SHALL be applied to div_reg and used for the reload at the next terminal count.
REQ-025 A load accepted on a terminal-count cycle SHALL be used for that same reload.
REQ-026 A pending value present when stop is taken SHALL be applied on the same edge.
REQ-027 tick_cnt SHALL increment on every tick and wrap from 15 to 0.
REQ-028 tick_cnt SHALL hold its value across stop and restart.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 While rst=0, the block SHALL asynchronously force: state IDLE, prescaler 0, pending cleared, div_reg=DIV_RST, tick_cnt=0, slow=0, running=0, div_ready=1.
REQ-031 Reset asserted mid-period SHALL discard the partial period and any pending load.
REQ-032 The first tick after reset SHALL require a fresh start.

Configuration
REQ-033 Without macro SLOW_TICK_SQUARE_EN defined, slow SHALL be a one-clock pulse on each tick.
REQ-034 With SLOW_TICK_SQUARE_EN defined, slow SHALL toggle on each tick, giving a square wave of period 2*(div_reg+1).
REQ-035 With SLOW_TICK_SQUARE_EN defined, slow SHALL hold its level in IDLE and reset to 0.
REQ-036 tick_cnt behaviour SHALL be identical with and without SLOW_TICK_SQUARE_EN.

Verification
REQ-037 Bench SHALL cover: reset release, start with div_reg=7 -> first slow pulse exactly 8 clocks after start, then every 8 clocks; tick_cnt 1,2,3...
REQ-038 Bench SHALL cover: 17 ticks -> tick_cnt wraps 15->0->1.
REQ-039 Bench SHALL cover: in RUN, div_load with div_val=2 mid-period -> div_ready=0, current period completes at 8 clocks, following periods are 3 clocks, div_ready returns to 1.
REQ-040 Bench SHALL cover: stop asserted on a terminal-count cycle -> no pulse, running=0, tick_cnt unchanged; later start resumes tick_cnt from its held value.
REQ-041 Bench SHALL cover: rst pulsed low mid-period with a pending load -> all outputs at reset values immediately, div_reg=7 after release.
REQ-042 Bench SHALL cover: div_val=0 with SLOW_TICK_SQUARE_EN defined -> slow toggles every clock; without the macro -> slow held at 1 continuously while running.

Source files
------------

// File: rtl/slow_tick_gen.sv
// slow_tick_gen: prescaler that turns core_clk into a slow enable for a downstream counter.
// Latency: the first tick is registered div_reg+1 clocks after start is accepted, then one every div_reg+1 clocks.
// Backpressure: div_ready drops while a divisor load is pending in RUN; div_load is ignored until it rises again.
// Optional macro SLOW_TICK_SQUARE_EN: slow toggles on each tick (square wave) instead of pulsing for one clock.
module slow_tick_gen #(
    parameter int               DIV_W   = 8,
    parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(7)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_val,
    output logic             div_ready,
    output logic             slow,
    output logic             running,
    output logic [3:0]       tick_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_presc;
    logic [DIV_W-1:0] r_div;
    logic             r_pend_vld;
    logic [DIV_W-1:0] r_pend_val;
    logic [3:0]       r_tick_cnt;
    logic             r_slow;
    logic             r_running;
    logic             r_div_ready;

    state_t           w_state_nxt;
    logic [DIV_W-1:0] w_presc_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic             w_pend_vld_nxt;
    logic [DIV_W-1:0] w_pend_val_nxt;
    logic [DIV_W-1:0] w_reload;
    logic             w_accept;
    logic             w_tick;
    logic             w_slow_nxt;

    // Next-state, prescaler and divisor bookkeeping for the two-state FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_presc_nxt    = r_presc;
        w_div_nxt      = r_div;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_val_nxt = r_pend_val;
        w_tick         = 1'b0;
        w_accept       = div_load & r_div_ready;
        // A load accepted on the same cycle as a reload wins; otherwise a pending value does.
        w_reload       = r_pend_vld ? r_pend_val : r_div;
        if (w_accept) begin
            w_reload = div_val;
        end

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_div_nxt = div_val;
                end
                if (start && !stop) begin
                    w_state_nxt = RUN;
                    w_presc_nxt = r_div;
                end
            end
            RUN: begin
                if (stop) begin
                    // Stop beats terminal count: no tick, but a pending divisor still lands.
                    w_state_nxt    = IDLE;
                    w_presc_nxt    = '0;
                    w_div_nxt      = w_reload;
                    w_pend_vld_nxt = 1'b0;
                end else if (r_presc == '0) begin
                    w_tick         = 1'b1;
                    w_presc_nxt    = w_reload;
                    w_div_nxt      = w_reload;
                    w_pend_vld_nxt = 1'b0;
                end else begin
                    w_presc_nxt = r_presc - DIV_W'(1);
                    if (w_accept) begin
                        w_pend_vld_nxt = 1'b1;
                        w_pend_val_nxt = div_val;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

`ifdef SLOW_TICK_SQUARE_EN
        w_slow_nxt = r_slow ^ w_tick;
`else
        w_slow_nxt = w_tick;
`endif
    end

    // State and datapath registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_presc     <= '0;
            r_div       <= DIV_RST;
            r_pend_vld  <= 1'b0;
            r_pend_val  <= '0;
            r_tick_cnt  <= 4'd0;
            r_slow      <= 1'b0;
            r_running   <= 1'b0;
            r_div_ready <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_presc     <= w_presc_nxt;
            r_div       <= w_div_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_val  <= w_pend_val_nxt;
            r_tick_cnt  <= r_tick_cnt + {3'd0, w_tick};
            r_slow      <= w_slow_nxt;
            r_running   <= (w_state_nxt == RUN);
            r_div_ready <= ~w_pend_vld_nxt;
        end
    end

    assign div_ready = r_div_ready;
    assign slow      = r_slow;
    assign running   = r_running;
    assign tick_cnt  = r_tick_cnt;

endmodule

// File: tb/tb_slow_tick_gen.sv
// Directed bench for slow_tick_gen: per-cycle vector table plus hand-written multi-cycle sequences.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Expected slow level follows the build: pulse per tick, or toggling level under SLOW_TICK_SQUARE_EN.
module tb_slow_tick_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       div_load = 1'b0;
    logic [7:0] div_val = 8'd0;
    logic       div_ready;
    logic       slow;
    logic       running;
    logic [3:0] tick_cnt;

    int n_vec = 0;
    int n_err = 0;
    bit sq_lvl = 1'b0;

    typedef struct {
        bit         start;
        bit         stop;
        bit         ld;
        logic [7:0] val;
        bit         tick;
        bit         run;
        bit         rdy;
        int         cnt;
    } vec_t;

    vec_t tbl [18];

    slow_tick_gen #(.DIV_W(8), .DIV_RST(8'd7)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .div_load (div_load),
        .div_val  (div_val),
        .div_ready(div_ready),
        .slow     (slow),
        .running  (running),
        .tick_cnt (tick_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // tk says whether a tick is due on the edge just passed.
    task automatic chk(input string nm, input bit tk, input bit run, input bit rdy, input int cnt);
        bit         es;
        logic [3:0] ec;
        ec = 4'(cnt);
`ifdef SLOW_TICK_SQUARE_EN
        if (tk) sq_lvl = ~sq_lvl;
        es = sq_lvl;
`else
        es = tk;
`endif
        n_vec++;
        if (slow !== es || running !== run || div_ready !== rdy || tick_cnt !== ec) begin
            n_err++;
            $display("FAIL %s: got slow=%b running=%b div_ready=%b tick_cnt=%0d, want slow=%b running=%b div_ready=%b tick_cnt=%0d",
                     nm, slow, running, div_ready, tick_cnt, es, run, rdy, ec);
        end
    endtask

    // One full period of len clocks ending in a tick that brings tick_cnt to cnt.
    task automatic period(input string nm, input int len, input int cnt);
        for (int i = 1; i < len; i++) begin
            cyc();
            chk(nm, 1'b0, 1'b1, 1'b1, (cnt + 15) % 16);
        end
        cyc();
        chk(nm, 1'b1, 1'b1, 1'b1, cnt % 16);
    endtask

    initial begin
        // Per-cycle vectors: inputs for the cycle, outputs expected after its edge.
        // Starts one cycle after a tick with div_reg=2 and tick_cnt=4.
        tbl[0]  = '{0, 0, 0, 8'd0, 0, 1, 1, 4};
        tbl[1]  = '{0, 0, 0, 8'd0, 0, 1, 1, 4};
        tbl[2]  = '{0, 1, 0, 8'd0, 0, 0, 1, 4};  // stop on terminal count: no tick
        tbl[3]  = '{0, 0, 0, 8'd0, 0, 0, 1, 4};
        tbl[4]  = '{1, 0, 0, 8'd0, 0, 1, 1, 4};  // restart from held count
        tbl[5]  = '{0, 0, 0, 8'd0, 0, 1, 1, 4};
        tbl[6]  = '{0, 0, 0, 8'd0, 0, 1, 1, 4};
        tbl[7]  = '{0, 0, 0, 8'd0, 1, 1, 1, 5};
        tbl[8]  = '{1, 0, 0, 8'd0, 0, 1, 1, 5};  // start ignored in RUN
        tbl[9]  = '{1, 1, 0, 8'd0, 0, 0, 1, 5};  // stop wins in RUN
        tbl[10] = '{1, 1, 0, 8'd0, 0, 0, 1, 5};  // start+stop in IDLE stays IDLE
        tbl[11] = '{0, 0, 1, 8'd0, 0, 0, 1, 5};  // div_reg <- 0
        tbl[12] = '{1, 0, 0, 8'd0, 0, 1, 1, 5};
        tbl[13] = '{0, 0, 0, 8'd0, 1, 1, 1, 6};  // tick every clock
        tbl[14] = '{0, 0, 0, 8'd0, 1, 1, 1, 7};
        tbl[15] = '{0, 0, 0, 8'd0, 1, 1, 1, 8};
        tbl[16] = '{0, 1, 0, 8'd0, 0, 0, 1, 8};
        tbl[17] = '{0, 0, 1, 8'd4, 0, 0, 1, 8};  // div_reg <- 4

        // Reset state.
        #1 rst = 1'b0;
        #20;
        chk("reset", 1'b0, 1'b0, 1'b1, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        cyc();
        chk("idle_no_start", 1'b0, 1'b0, 1'b1, 0);

        // div_reg=7: tick 8 clocks after start, then every 8; 17 ticks wrap the count.
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_accept", 1'b0, 1'b1, 1'b1, 0);
        for (int t = 1; t <= 17; t++) begin
            period($sformatf("div7_tick%0d", t), 8, t % 16);
        end

        // Mid-period load of 2: current period stays 8, following ones are 3.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("ld_pre", 1'b0, 1'b1, 1'b1, 1);
        end
        div_load = 1'b1;
        div_val  = 8'd2;
        cyc();
        div_load = 1'b0;
        div_val  = 8'd0;
        chk("ld_accept", 1'b0, 1'b1, 1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            div_load = 1'b1;
            div_val  = 8'd9;  // must be ignored while div_ready=0
            cyc();
            chk("ld_pending", 1'b0, 1'b1, 1'b0, 1);
        end
        div_load = 1'b0;
        div_val  = 8'd0;
        cyc();
        chk("ld_old_period_end", 1'b1, 1'b1, 1'b1, 2);
        period("div2_a", 3, 3);
        period("div2_b", 3, 4);

        // Table-driven stop/restart, IDLE handshake and div_reg=0.
        for (int i = 0; i < 18; i++) begin
            start    = tbl[i].start;
            stop     = tbl[i].stop;
            div_load = tbl[i].ld;
            div_val  = tbl[i].val;
            cyc();
            start    = 1'b0;
            stop     = 1'b0;
            div_load = 1'b0;
            div_val  = 8'd0;
            chk($sformatf("tbl%0d", i), tbl[i].tick, tbl[i].run, tbl[i].rdy, tbl[i].cnt);
        end

        // Reset mid-period with a pending load: div_reg must come back as 7.
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("rst_seq_start", 1'b0, 1'b1, 1'b1, 8);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("rst_seq_run", 1'b0, 1'b1, 1'b1, 8);
        end
        div_load = 1'b1;
        div_val  = 8'd2;
        cyc();
        div_load = 1'b0;
        div_val  = 8'd0;
        chk("rst_seq_pend", 1'b0, 1'b1, 1'b0, 8);
        #3 rst = 1'b0;
        #1;
        sq_lvl = 1'b0;
        chk("rst_async", 1'b0, 1'b0, 1'b1, 0);
        #1 rst = 1'b1;
        cyc();
        chk("rst_needs_start", 1'b0, 1'b0, 1'b1, 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("rst_restart", 1'b0, 1'b1, 1'b1, 0);
        period("post_rst_1", 8, 1);
        period("post_rst_2", 8, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
